mem_init_fsm_param: RTL and testbench
=====================================

Name: mem_init_fsm_param

Overview:
Parametrised memory initialiser that sweeps a single-port RAM from address 0 to DEPTH-1 and writes one word per accepted cycle. It is the generalised successor to the fixed 256x8 identity-fill initialiser. It adds:
- selectable fill modes
- configurable width and depth
- a write-ready stall handshake
- abort

It sits between the top-level control FSM and the working RAM, ahead of the swap/decrypt stages.

Parameters:
ADDR_W, 8, address width in bits.
DATA_W, 8, data width in bits.
DEPTH, 256, number of words to initialise. Legal range is 1 <= DEPTH <= 2**ADDR_W; elaboration error otherwise.

Ports:
clk  input  1  rising-edge clock; the block uses one clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  level; sampled only in IDLE.
mode  input  2  fill mode; captured when start is accepted.
fill_value  input  DATA_W  constant/base operand; captured when start is accepted.
wr_ready  input  1  memory can accept a write this cycle.
abort  input  1  terminate the sweep early.
wr_en  output  1  write strobe.
mem_addr  output  ADDR_W  write address.
wr_data  output  DATA_W  write data.
busy  output  1  high in WRITE and DONE.
finish  output  1  one-cycle pulse on normal completion.
aborted  output  1  one-cycle pulse on abort.

Behaviour:
- Reset (async, rst=1): state=IDLE, addr=0, captured mode/fill_value=0. All outputs are 0 while rst is high and until the first start.
- States: IDLE, WRITE, DONE, ABORTED. All are registered; outputs are decoded from state and registers only, with no input-to-output combinational path.
- IDLE:
  - start=1 -> capture mode and fill_value, set addr=0, go to WRITE.
  - start=0 -> stay in IDLE.
- WRITE:
  - wr_en=1, mem_addr=addr, wr_data=f(mode, addr).
  - A write is accepted on a clock edge where wr_en=1 and wr_ready=1.
  - Accepted with addr==DEPTH-1 -> go to DONE; addr holds.
  - Accepted with addr<DEPTH-1 -> addr+1, stay in WRITE.
  - wr_ready=0 -> hold; mem_addr and wr_data must stay stable.
- abort=1 in WRITE -> go to ABORTED. Abort takes priority over a same-cycle accept: the write on that edge still completes at the memory, but addr does not advance.
- abort in IDLE or DONE is ignored.
- DONE: finish=1 for exactly one cycle, then go to IDLE. start is ignored while in DONE.
- ABORTED: aborted=1 for exactly one cycle, then go to IDLE. addr is left at its last value and reset to 0 on the next start.
- start is ignored while busy; there is no re-trigger mid-sweep.
- Data function, computed in DATA_W bits, modulo 2**DATA_W:
  - mode 0 identity: addr, zero-extended or truncated to DATA_W.
  - mode 1 constant: fill_value.
  - mode 2 offset: fill_value + addr.
  - mode 3 descending: (DEPTH-1) - addr.
- Latency with wr_ready held high: start is sampled on edge E0, the first wr_en is visible after E0, and the last write is accepted on edge E0+DEPTH. finish is high for the cycle after edge E0+DEPTH. Total is DEPTH+1 cycles from the start edge until the return to IDLE.
- DEPTH=1: a single write, then DONE.
- DEPTH=2**ADDR_W: the final address is all-ones and must not wrap to 0 before DONE.
- A reset asserted mid-sweep aborts immediately and silently: no finish and no aborted pulse.
- Mode and fill_value changes while busy have no effect on the current sweep.

Test Plan:
- Defaults, mode 0, wr_ready=1, pulse start: 256 writes, addr=data=0x00..0xFF in consecutive cycles. finish is high for exactly 1 cycle, 256 cycles after the start edge, and there is no write to address 0x100 or back at 0.
- Mode 2, fill_value=0xF0, DEPTH=256: data at addr 0x0F is 0xFF and at addr 0x10 is 0x00 (wrap). Mode 3: addr 0 has data 0xFF and addr 0xFF has data 0x00.
- Mode 1, fill_value=0x5A, wr_ready toggling 1,0,0,1 at random: every address 0..255 is written exactly once with 0x5A. mem_addr and wr_data are stable throughout each stall, and finish is delayed by the number of stall cycles.
- abort raised while addr=0x40 and wr_ready=1: aborted pulses once, finish never pulses, no address above 0x40 is written. A following start restarts the sweep at addr 0.
- rst asserted asynchronously mid-sweep (not on an edge): wr_en, busy, finish and aborted drop to 0 immediately. start held high during DONE does not launch a second sweep until IDLE is reached.
- DEPTH=1 and ADDR_W=4/DATA_W=16/DEPTH=16: exactly 1 and exactly 16 writes respectively. Mode 0 data is zero-extended, e.g. addr 0xF gives data 0x000F.

Source files
------------

// File: rtl/mem_init_fsm_param.sv
// Parametrised RAM initialiser: sweeps addresses 0..DEPTH-1, one word per accepted write,
// with selectable fill pattern, write-ready stall and early abort.
module mem_init_fsm_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              wr_ready,
    input  logic              abort,
    output logic              wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              finish,
    output logic              aborted
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2,
        ABORTED = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] LAST_DATA = DATA_W'(DEPTH - 1);

    generate
        if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
            $error("mem_init_fsm_param: DEPTH must lie in 1 .. 2**ADDR_W");
        end
    endgenerate

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [1:0]        mode_q, mode_next;
    logic [DATA_W-1:0] fill_q, fill_next;
    logic [DATA_W-1:0] fill_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            mode_q <= '0;
            fill_q <= '0;
        end else begin
            state  <= state_next;
            addr   <= addr_next;
            mode_q <= mode_next;
            fill_q <= fill_next;
        end
    end

    // Abort wins over a same-edge accept: the memory still takes that write,
    // but the address does not advance.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        mode_next  = mode_q;
        fill_next  = fill_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WRITE;
                    addr_next  = '0;
                    mode_next  = mode;
                    fill_next  = fill_value;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_next = ABORTED;
                end else if (wr_ready) begin
                    if (addr == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        addr_next = addr + 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            ABORTED: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fill_data = '0;
        case (mode_q)
            2'd0: fill_data = DATA_W'(addr);
            2'd1: fill_data = fill_q;
            2'd2: fill_data = fill_q + DATA_W'(addr);
            2'd3: fill_data = LAST_DATA - DATA_W'(addr);
            default: fill_data = '0;
        endcase
    end

    // Outputs depend only on registered state, never directly on inputs.
    always_comb begin
        wr_en    = (state == WRITE);
        busy     = (state == WRITE) || (state == DONE);
        finish   = (state == DONE);
        aborted  = (state == ABORTED);
        mem_addr = addr;
        wr_data  = (state == WRITE) ? fill_data : '0;
    end

endmodule

// File: tb/tb_mem_init_fsm_param.sv
// Bench for mem_init_fsm_param: three configurations (256x8, depth 1, 16x16) checked
// against an arithmetic fill model and a scoreboard of accepted writes.
module tb_mem_init_fsm_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] fill = 16'h0;
    logic        wr_ready = 1'b1;
    logic        abort = 1'b0;

    logic        wr_en_a, busy_a, finish_a, aborted_a;
    logic [7:0]  mem_addr_a, wr_data_a;
    logic        wr_en_b, busy_b, finish_b, aborted_b;
    logic [7:0]  mem_addr_b, wr_data_b;
    logic        wr_en_c, busy_c, finish_c, aborted_c;
    logic [3:0]  mem_addr_c;
    logic [15:0] wr_data_c;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_a[$], got_b[$], got_c[$];
    int fin_cnt_a = 0, fin_cyc_a = 0, ab_cnt_a = 0, stall_cnt_a = 0;
    int fin_cnt_b = 0, fin_cyc_b = 0, fin_cnt_c = 0, fin_cyc_c = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] held_addr = 8'h0, held_data = 8'h0;

    mem_init_fsm_param #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .fill_value(fill[7:0]),
        .wr_ready(wr_ready), .abort(abort), .wr_en(wr_en_a), .mem_addr(mem_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .finish(finish_a), .aborted(aborted_a)
    );
    mem_init_fsm_param #(.ADDR_W(8), .DATA_W(8), .DEPTH(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .fill_value(fill[7:0]),
        .wr_ready(wr_ready), .abort(abort), .wr_en(wr_en_b), .mem_addr(mem_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .finish(finish_b), .aborted(aborted_b)
    );
    mem_init_fsm_param #(.ADDR_W(4), .DATA_W(16), .DEPTH(16)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode), .fill_value(fill),
        .wr_ready(wr_ready), .abort(abort), .wr_en(wr_en_c), .mem_addr(mem_addr_c),
        .wr_data(wr_data_c), .busy(busy_c), .finish(finish_c), .aborted(aborted_c)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- monitors (sampled on the falling edge) ----------------
    always @(negedge clk) begin
        if (wr_en_a && stall_prev) begin
            check("stall_addr_stable", 32'(mem_addr_a), 32'(held_addr));
            check("stall_data_stable", 32'(wr_data_a), 32'(held_data));
        end
        stall_prev = wr_en_a && !wr_ready && !abort && !rst;
        held_addr  = mem_addr_a;
        held_data  = wr_data_a;
        if (wr_en_a && !wr_ready) stall_cnt_a++;
        if (wr_en_a && wr_ready) got_a.push_back({16'(mem_addr_a), 16'(wr_data_a)});
        if (finish_a) begin fin_cnt_a++; fin_cyc_a = cyc; end
        if (aborted_a) ab_cnt_a++;
        if (wr_en_b && wr_ready) got_b.push_back({16'(mem_addr_b), 16'(wr_data_b)});
        if (finish_b) begin fin_cnt_b++; fin_cyc_b = cyc; end
        if (wr_en_c && wr_ready) got_c.push_back({16'(mem_addr_c), 16'(wr_data_c)});
        if (finish_c) begin fin_cnt_c++; fin_cyc_c = cyc; end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(int a, int m, int f, int depth, int dw);
        longint d;
        longint mask;
        mask = (longint'(1) << dw) - 1;
        case (m)
            0: d = a;
            1: d = f;
            2: d = f + a;
            default: d = (depth - 1) - a;
        endcase
        d = d & mask;
        return {16'(a), 16'(d)};
    endfunction

    function automatic logic busy_of(int w);
        return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int w, input int m, input int f, output int c0);
        @(posedge clk); #1;
        mode = 2'(m);
        fill = 16'(f);
        if (w == 0) start_a = 1'b1; else if (w == 1) start_b = 1'b1; else start_c = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_idle(input int w, input int bound, input string tag);
        int n = 0;
        while (busy_of(w) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(busy_of(w)), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_a.delete(); got_b.delete(); got_c.delete();
        fin_cnt_a = 0; ab_cnt_a = 0; stall_cnt_a = 0; fin_cnt_b = 0; fin_cnt_c = 0;
    endtask

    // Scoreboard: expected write list for the first n addresses of a sweep.
    task automatic compare_q(input int w, input int n, input int m, input int f,
                             input int depth, input int dw, input string tag);
        logic [31:0] g[$];
        exp_q.delete();
        for (int a = 0; a < n; a++) exp_q.push_back(model(a, m, f, depth, dw));
        g = (w == 0) ? got_a : (w == 1) ? got_b : got_c;
        check({tag, "_count"}, 32'(g.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < g.size(); i++)
            check({tag, "_write"}, g[i], exp_q[i]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        int n;
        #2 rst = 1'b1;
        #1;
        check("rst_wr_en", 32'(wr_en_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_addr_data", {16'(mem_addr_a), 16'(wr_data_a)}, 0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", {28'(0), wr_en_a, busy_a, finish_a, aborted_a}, 0);
        check("idle_addr_data", {16'(mem_addr_a), 16'(wr_data_a)}, 0);

        // abort in IDLE has no effect
        abort = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_abort_ignored", {30'(0), busy_a, aborted_a}, 0);
        abort = 1'b0;

        // Identity sweep, ready always high.
        clear_logs();
        pulse_start(0, 0, 0, c0);
        wait_idle(0, 400, "mode0_timeout");
        compare_q(0, 256, 0, 0, 256, 8, "mode0");
        check("mode0_finish_count", 32'(fin_cnt_a), 1);
        check("mode0_finish_cycle", 32'(fin_cyc_a), 32'(c0 + 256));

        // Offset with wrap, then descending.
        clear_logs();
        pulse_start(0, 2, 'hF0, c0);
        wait_idle(0, 400, "mode2_timeout");
        compare_q(0, 256, 2, 'hF0, 256, 8, "mode2");
        if (got_a.size() == 256) begin
            check("mode2_addr0f", got_a[15], 32'h000F_00FF);
            check("mode2_addr10", got_a[16], 32'h0010_0000);
        end
        clear_logs();
        pulse_start(0, 3, $urandom, c0);
        wait_idle(0, 400, "mode3_timeout");
        compare_q(0, 256, 3, 0, 256, 8, "mode3");
        if (got_a.size() == 256) begin
            check("mode3_addr00", got_a[0], 32'h0000_00FF);
            check("mode3_addrff", got_a[255], 32'h00FF_0000);
        end

        // Constant fill with random stalls; mode/fill scrambled mid-sweep.
        clear_logs();
        pulse_start(0, 1, 'h5A, c0);
        n = 0;
        while (busy_a && n < 2000) begin
            @(posedge clk); #1;
            wr_ready = 1'($urandom_range(0, 1));
            mode = 2'($urandom);
            fill = 16'($urandom);
            n++;
        end
        wr_ready = 1'b1;
        wait_idle(0, 10, "stall_timeout");
        compare_q(0, 256, 1, 'h5A, 256, 8, "stall");
        check("stall_finish_count", 32'(fin_cnt_a), 1);
        check("stall_finish_cycle", 32'(fin_cyc_a), 32'(c0 + 256 + stall_cnt_a));

        // Abort at address 0x40 with ready high, then restart from 0.
        clear_logs();
        pulse_start(0, 0, 0, c0);
        n = 0;
        while (mem_addr_a != 8'h40 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach_40", 32'(mem_addr_a), 32'h40);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(0, 10, "abort_timeout");
        compare_q(0, 'h41, 0, 0, 256, 8, "abort");
        check("abort_pulse_count", 32'(ab_cnt_a), 1);
        check("abort_no_finish", 32'(fin_cnt_a), 0);
        clear_logs();
        pulse_start(0, 0, 0, c0);
        wait_idle(0, 400, "restart_timeout");
        compare_q(0, 256, 0, 0, 256, 8, "restart");
        check("restart_finish_count", 32'(fin_cnt_a), 1);

        // start held through DONE must wait for IDLE before relaunching.
        clear_logs();
        pulse_start(0, 0, 0, c0);
        n = 0;
        while (mem_addr_a != 8'hFE && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        start_a = 1'b1;
        n = 0;
        while (!finish_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_start_done", 32'(finish_a), 1);
        @(posedge clk); #1;
        check("held_start_idle", {30'(0), busy_a, wr_en_a}, 0);
        @(posedge clk); #1;
        check("held_start_relaunch", {15'(0), busy_a, 16'(mem_addr_a)}, 32'h0001_0000);
        start_a = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(0, 10, "held_abort_timeout");
        check("held_first_sweep_finish", 32'(fin_cnt_a), 1);

        // Asynchronous reset mid-sweep, away from any clock edge.
        clear_logs();
        pulse_start(0, 2, $urandom, c0);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_outputs", {28'(0), wr_en_a, busy_a, finish_a, aborted_a}, 0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("async_rst_silent", 32'(fin_cnt_a + ab_cnt_a), 0);
        check("async_rst_idle", {30'(0), busy_a, wr_en_a}, 0);

        // DEPTH=1: one write, then DONE.
        clear_logs();
        n = $urandom_range(0, 255);
        pulse_start(1, 2, n, c0);
        wait_idle(1, 20, "depth1_timeout");
        compare_q(1, 1, 2, n, 1, 8, "depth1");
        check("depth1_finish_cycle", 32'(fin_cyc_b), 32'(c0 + 1));
        check("depth1_finish_count", 32'(fin_cnt_b), 1);

        // 16 x 16: identity zero-extended, then descending over full address space.
        clear_logs();
        pulse_start(2, 0, $urandom, c0);
        wait_idle(2, 40, "w16_timeout");
        compare_q(2, 16, 0, 0, 16, 16, "w16_mode0");
        if (got_c.size() == 16) check("w16_addr_f", got_c[15], 32'h000F_000F);
        check("w16_finish_cycle", 32'(fin_cyc_c), 32'(c0 + 16));
        clear_logs();
        pulse_start(2, 3, 0, c0);
        wait_idle(2, 40, "w16d_timeout");
        compare_q(2, 16, 3, 0, 16, 16, "w16_mode3");
        check("w16_finish_count", 32'(fin_cnt_c), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "global timeout");
    end

endmodule
